branch_resolve: RTL

- Consumer stage for the magnitude comparer's one-hot result f[2:0]: f[2] = a>b, f[1] = a<b, f[0] = a==b.
- The comparer is unsigned only. This block applies the signed fix-up using the operand sign bits.
- Decodes the RISC-V branch funct3, decides taken/not-taken and computes next PC.
- Presents the result through a registered valid/ready output stage that feeds the PC-select logic.

---
 rtl/branch_pkg.sv | 27 ++
 rtl/branch_decide.sv | 45 ++++
 rtl/branch_resolve.sv | 102 ++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared branch-resolution definitions: funct3 encodings, comparer flag indices, stage state.
// Latency: none (declarations only).
// Backpressure: not applicable.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Bit positions inside the comparer's one-hot result {gt, lt, eq}.
    localparam int CMP_GT = 2;
    localparam int CMP_LT = 1;
    localparam int CMP_EQ = 0;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_t;

    function automatic logic cmp_is_onehot(input logic [2:0] f);
        return (f == 3'b001) || (f == 3'b010) || (f == 3'b100);
    endfunction

endpackage

// File: rtl/branch_decide.sv
// Branch decision: signed fix-up of unsigned compare flags and funct3 decode to taken/illegal.
// Latency: purely combinational.
// Backpressure: none; the caller registers the result.
// Ports: funct3 (branch type), cmp_f {gt,lt,eq}, a_msb/b_msb (operand sign bits)
//        -> taken, illegal (bad funct3 or cmp_f not one-hot).
module branch_decide
    import branch_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [2:0] cmp_f,
    input  logic       a_msb,
    input  logic       b_msb,
    output logic       taken,
    output logic       illegal
);

    logic ult;
    logic eq;
    logic slt;

    assign ult = cmp_f[CMP_LT];
    assign eq  = cmp_f[CMP_EQ];
    // Differing sign bits decide signed order directly: the negative operand is smaller.
    // Equal sign bits mean the unsigned ordering already matches the signed one.
    assign slt = (a_msb != b_msb) ? a_msb : cmp_f[CMP_LT];

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        if (!cmp_is_onehot(cmp_f)) begin
            illegal = 1'b1;
        end else begin
            unique case (funct3)
                F3_BEQ:  taken = eq;
                F3_BNE:  taken = !eq;
                F3_BLT:  taken = slt;
                F3_BGE:  taken = !slt;
                F3_BLTU: taken = ult;
                F3_BGEU: taken = !ult;
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolve stage: decides taken/not-taken and next PC, presented via a registered valid/ready slot.
// Latency: 1 cycle from input transfer to result on outputs; full throughput when out_ready=1.
// Backpressure: in_ready = !out_valid || out_ready; a held result stays stable until consumed.
// Ports: clk, rst_n (sync active-low); in_valid/in_ready, funct3, cmp_f, a_msb, b_msb, pc, imm;
//        out_valid/out_ready, taken, next_pc, illegal.
// Optional macro BRANCH_RESOLVE_STATS_EN adds stat_clr, stat_total, stat_taken (saturating counters).
module branch_resolve
    import branch_pkg::*;
#(
    parameter int N       = 32,
    parameter int PC_STEP = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   funct3,
    input  logic [2:0]   cmp_f,
    input  logic         a_msb,
    input  logic         b_msb,
    input  logic [N-1:0] pc,
    input  logic [N-1:0] imm,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         taken,
    output logic [N-1:0] next_pc,
    output logic         illegal
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    input  logic         stat_clr,
    output logic [15:0]  stat_total,
    output logic [15:0]  stat_taken
`endif
);

    stage_state_t state;
    stage_state_t state_nxt;

    logic         in_xfer;
    logic         taken_d;
    logic         illegal_d;
    logic [N-1:0] next_pc_d;

    branch_decide u_decide (
        .funct3  (funct3),
        .cmp_f   (cmp_f),
        .a_msb   (a_msb),
        .b_msb   (b_msb),
        .taken   (taken_d),
        .illegal (illegal_d)
    );

    // Illegal requests never report taken, so they fall through to the sequential PC.
    assign next_pc_d = taken_d ? (pc + imm) : (pc + N'(PC_STEP));

    assign out_valid = (state == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign in_xfer   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_EMPTY: if (in_xfer) state_nxt = ST_FULL;
            ST_FULL: begin
                if (in_xfer)        state_nxt = ST_FULL;
                else if (out_ready) state_nxt = ST_EMPTY;
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // Result payload only moves on an input transfer, which keeps it stable under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            taken   <= 1'b0;
            illegal <= 1'b0;
            next_pc <= '0;
        end else if (in_xfer) begin
            taken   <= taken_d;
            illegal <= illegal_d;
            next_pc <= next_pc_d;
        end
    end

`ifdef BRANCH_RESOLVE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n || stat_clr) begin
            stat_total <= '0;
            stat_taken <= '0;
        end else if (in_xfer) begin
            if (!illegal_d && stat_total != 16'hFFFF) stat_total <= stat_total + 16'd1;
            if (taken_d && stat_taken != 16'hFFFF)    stat_taken <= stat_taken + 16'd1;
        end
    end
`endif

endmodule
